ifu: RTL and testbench



---
 rtl/ifu.sv | 98 +++++++++
 tb/tb_ifu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit for a single-cycle MIPS core.
//
// Holds the program counter and a byte-addressed, big-endian instruction
// memory. The instruction at the current PC is presented combinationally.
// PC is updated on every rising clock edge: jump beats branch, and branch
// beats sequential.
//
// Ports:
//   clk         in   1   system clock, all state on rising edge
//   reset       in   1   synchronous active-high reset (PC <= RESET_PC)
//   instruction out  32  word at current PC (combinational)
//   imm16       in   16  branch offset in words, two's complement
//   addr26      in   26  jump target word index
//   is_jump     in   1   next PC = {PC[31:28], addr26, 2'b00}
//   is_branch   in   1   next PC = PC + (sext(imm16) << 2)
// ---------------------------------------------------------------------------

// Raw byte store. Contents are preloaded from outside through the
// hierarchical path storage.bytes. The memory has no write path of its own.
module ifu_storage #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [$clog2(IMEM_BYTES)-3:0] waddr_i,
    output logic [31:0]                   word_o
);
    localparam int AW = $clog2(IMEM_BYTES);

    logic [7:0] bytes [0:IMEM_BYTES-1];

    logic [AW-1:0] base;
    assign base = {waddr_i, 2'b00};

    // Big-endian: the lowest address holds the most significant byte.
    assign word_o = {bytes[base],
                     bytes[base | AW'(1)],
                     bytes[base | AW'(2)],
                     bytes[base | AW'(3)]};
endmodule

// Asynchronous-read instruction memory wrapper. It takes the word address
// only; the PC bits above the memory size are dropped here, which gives the
// modulo-size wrap.
module ifu_imem #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [$clog2(IMEM_BYTES)-3:0] waddr_i,
    output logic [31:0]                   rdata_o
);
    ifu_storage #(.IMEM_BYTES(IMEM_BYTES)) storage (
        .waddr_i (waddr_i),
        .word_o  (rdata_o)
    );
endmodule

module ifu #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instruction,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    input  logic        is_jump,
    input  logic        is_branch
);
    localparam int AW = $clog2(IMEM_BYTES);

    // The PC starts at RESET_PC at time zero, before any reset pulse.
    logic [31:0] pc_q = RESET_PC;
    logic [31:0] pc_d;
    logic [31:0] br_off;

    // Word offset sign-extended and scaled to bytes. It is added to the
    // current PC, not to PC+4.
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (is_jump)
            pc_d = {pc_q[31:28], addr26, 2'b00};
        else if (is_branch)
            pc_d = pc_q + br_off;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    ifu_imem #(.IMEM_BYTES(IMEM_BYTES)) imemory (
        .waddr_i (pc_q[AW-1:2]),
        .rdata_o (instruction)
    );
endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
    localparam logic [31:0] INSTR_0 = 32'hCA0F3355;
    localparam logic [31:0] INSTR_1 = 32'h00330FFF;
    localparam logic [31:0] INSTR_2 = 32'h20040008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction;
    logic [15:0] imm16 = '0;
    logic [25:0] addr26 = '0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;

    int vectors = 0;
    int errors  = 0;

    ifu #(.IMEM_BYTES(1024), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .imm16       (imm16),
        .addr26      (addr26),
        .is_jump     (is_jump),
        .is_branch   (is_branch)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle well away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        dut.imemory.storage.bytes[a]   = w[31:24];
        dut.imemory.storage.bytes[a+1] = w[23:16];
        dut.imemory.storage.bytes[a+2] = w[15:8];
        dut.imemory.storage.bytes[a+3] = w[7:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; addr26 = 26'd7;
        tick();
        reset = 1'b0;
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL reset: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
    endtask

    task automatic test_sequential();
        tick();
        vectors++;
        if (dut.pc_q !== 32'h4 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL seq1: pc=%h instr=%h want pc=4 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
        tick();
        vectors++;
        if (dut.pc_q !== 32'h8 || instruction !== INSTR_2) begin
            errors++;
            $display("FAIL seq2: pc=%h instr=%h want pc=8 instr=%h", dut.pc_q, instruction, INSTR_2);
        end
    endtask

    task automatic test_jump();
        is_jump = 1'b1; addr26 = 26'd0;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL jump0: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
        addr26 = 26'd2;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h8 || instruction !== INSTR_2) begin
            errors++;
            $display("FAIL jump2: pc=%h instr=%h want pc=8 instr=%h", dut.pc_q, instruction, INSTR_2);
        end
        is_jump = 1'b0;
    endtask

    task automatic test_branch();
        is_branch = 1'b1; imm16 = 16'hFFFE;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL br_m2: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
        is_branch = 1'b0;
        tick();
        tick();
        vectors++;
        if (dut.pc_q !== 32'h8) begin
            errors++;
            $display("FAIL br_seq: pc=%h want pc=8", dut.pc_q);
        end
        is_branch = 1'b1; imm16 = 16'hFFFF;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h4 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL br_m1: pc=%h instr=%h want pc=4 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
        is_branch = 1'b0;
        tick();  // PC = 8
    endtask

    task automatic test_priority();
        is_jump = 1'b1; is_branch = 1'b1; addr26 = 26'd1; imm16 = 16'hFFFE;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h4 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL jmp_over_br: pc=%h instr=%h want pc=4 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
        is_jump = 1'b0; is_branch = 1'b0;
    endtask

    task automatic test_reset_override();
        reset = 1'b1; is_jump = 1'b1; addr26 = 26'd2;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL rst_over_jmp: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
        reset = 1'b0; is_jump = 1'b0;
    endtask

    task automatic test_reset_midseq();
        tick();
        tick();
        vectors++;
        if (dut.pc_q !== 32'h8) begin
            errors++;
            $display("FAIL mid_pre: pc=%h want pc=8", dut.pc_q);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL mid_rst: pc=%h instr=%h want pc=0", dut.pc_q, instruction);
        end
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0) begin
            errors++;
            $display("FAIL mid_hold: pc=%h want pc=0", dut.pc_q);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h4 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL mid_rel: pc=%h instr=%h want pc=4 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
    endtask

    // Input changes between edges must not move the PC or the instruction.
    task automatic test_between_edges();
        is_jump = 1'b1; addr26 = 26'd0; is_branch = 1'b1; imm16 = 16'h0010;
        #1;
        vectors++;
        if (dut.pc_q !== 32'h4 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL no_edge: pc=%h instr=%h want pc=4 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
        is_jump = 1'b0; is_branch = 1'b0;
    endtask

    // Boundary cases: memory wrap past IMEM_BYTES and 32-bit PC wrap.
    task automatic test_wrap();
        is_jump = 1'b1; addr26 = 26'd257;  // byte 0x404 -> index 4
        tick();
        vectors++;
        if (dut.pc_q !== 32'h404 || instruction !== INSTR_1) begin
            errors++;
            $display("FAIL mem_wrap: pc=%h instr=%h want pc=404 instr=%h", dut.pc_q, instruction, INSTR_1);
        end
        addr26 = 26'd0;
        tick();
        is_jump = 1'b0; is_branch = 1'b1; imm16 = 16'hFFFF;
        tick();
        vectors++;
        if (dut.pc_q !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL pc_under: pc=%h want pc=fffffffc", dut.pc_q);
        end
        is_branch = 1'b0;
        tick();
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL pc_over: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
        // Jump keeps the upper nibble of the current PC.
        is_branch = 1'b1; imm16 = 16'hFFFE;  // PC -> fffffff8
        tick();
        is_branch = 1'b0; is_jump = 1'b1; addr26 = 26'd2;
        tick();
        vectors++;
        if (dut.pc_q !== 32'hF000_0008) begin
            errors++;
            $display("FAIL jmp_nibble: pc=%h want pc=f0000008", dut.pc_q);
        end
        is_jump = 1'b0;
    endtask

    initial begin
        put_word(0, INSTR_0);
        put_word(4, INSTR_1);
        put_word(8, INSTR_2);
        #1;
        vectors++;
        if (dut.pc_q !== 32'h0 || instruction !== INSTR_0) begin
            errors++;
            $display("FAIL time0: pc=%h instr=%h want pc=0 instr=%h", dut.pc_q, instruction, INSTR_0);
        end
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_priority();
        test_reset_override();
        test_reset_midseq();
        test_between_edges();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
